commit_monitor: RTL and testbench
=================================

Name: commit_monitor

Overview:
Synthesizable retire-side monitor that replaces bench-only end-of-test and CPI bookkeeping. It sits between the CPU debug commit outputs and the memory model's finish/done handshake, and supports 1..4 retire lanes for future superscalar cores. It checks PC sequencing, counts cycles and retired instructions, and detects the end-of-test PC. It drives finish to the memory model, waits for the write drain, and reports pass, fail or timeout.

Parameters:
ADDR_WIDTH, 32, PC width
RETIRE_W, 1, retire lanes per cycle (1..4)
CNT_WIDTH, 32, width of the cycle and instruction counters
RESET_PC, 0, PC expected on the first commit
END_PC, 88, commit of this PC ends the test
TIMEOUT_CYCLES, 100000, maximum cycles allowed between commits in RUN
DRAIN_TIMEOUT, 1024, maximum cycles allowed in DRAIN waiting for mem_done_i

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
commit_valid_i  in  RETIRE_W  per-lane commit strobe
commit_pc_i  in  RETIRE_W*ADDR_WIDTH  PC of lane k at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
commit_next_pc_i  in  RETIRE_W*ADDR_WIDTH  architectural next PC of lane k
mem_done_i  in  1  memory model has completed all pending writes
finish_o  out  1  request to the memory model to drain
cycle_count_o  out  CNT_WIDTH  cycles spent in RUN
instr_count_o  out  CNT_WIDTH  retired instructions
last_pc_o  out  ADDR_WIDTH  PC of the most recent accepted commit
seq_error_o  out  1  sticky sequencing error
seq_error_pc_o  out  ADDR_WIDTH  offending PC of the first error
timeout_o  out  1  sticky watchdog or drain timeout
done_o  out  1  test complete, in DONE or FAIL
pass_o  out  1  done_o && !seq_error_o && !timeout_o

Behaviour:
- Reset values: all outputs 0. Expected PC register (exp_pc) = RESET_PC. State = RUN.
- States: RUN, DRAIN, DONE, FAIL. DONE and FAIL are terminal; only reset leaves them.
- RUN counting:
  - cycle_count_o increments every cycle, including the cycle that retires END_PC.
  - Both counters saturate at all-ones and never wrap.
- Lane packing: lanes must be packed. If lane k is valid, lanes 0..k-1 must be valid. A gap sets seq_error with seq_error_pc = PC of the first valid lane above the gap.
- Per-cycle sequencing check, lanes in ascending order:
  - Lane 0 PC must equal exp_pc.
  - Lane k>0 PC must equal commit_next_pc of lane k-1.
  - A mismatch sets seq_error_o. seq_error_pc_o latches the first offending PC only.
  - Counting and exp_pc update continue after an error.
- Per-cycle updates:
  - instr_count_o += number of valid lanes accepted.
  - exp_pc <= next_pc of the highest accepted lane.
  - last_pc_o <= PC of the highest accepted lane.
- End of test:
  - If any accepted lane has PC == END_PC, lanes above it are not accepted and not counted; each such valid lane sets seq_error.
  - finish_o rises the next cycle and the state goes to DRAIN.
- Watchdog: idle counter clears on any commit and increments otherwise. When it reaches TIMEOUT_CYCLES: timeout_o=1, go to FAIL.
- DRAIN:
  - finish_o held at 1; counters frozen.
  - Any commit_valid sets seq_error (post-end retire) and is not counted.
  - mem_done_i=1 -> DONE. mem_done_i sampled high on the first DRAIN cycle is accepted.
  - Drain counter reaching DRAIN_TIMEOUT -> timeout_o=1, FAIL.
- DONE: finish_o stays 1; done_o=1; pass_o as defined.
- FAIL: finish_o=1; done_o=1; pass_o=0.
- Reset mid-operation: all state returns to reset values asynchronously; no residual counts or errors.
- Simultaneous events:
  - A commit and the watchdog threshold in the same cycle: the commit wins and the idle counter clears.
  - mem_done_i and DRAIN_TIMEOUT in the same cycle: DONE wins.

Test Plan:
- RETIRE_W=1: commit PCs 0,4,...,88 one per cycle, each next_pc=pc+4. mem_done_i rises 3 cycles after finish_o -> instr_count=23, cycle_count=23, finish_o rises the cycle after PC 88, pass_o=1.
- Branch: commit PC 8 with next_pc 40, then PC 40 -> no error. Then commit PC 48 where 44 is expected -> seq_error_o=1, seq_error_pc_o=48, counting continues.
- RETIRE_W=2, TIMEOUT_CYCLES=16: lanes {0,4},{8,12}, then valid=2'b10 -> gap error. Then no commits for 16 cycles -> timeout_o=1, FAIL, pass_o=0.
- RETIRE_W=2: lanes {84,88} accepted. Next cycle a commit in DRAIN -> seq_error_o=1, instr_count unchanged.
- DRAIN_TIMEOUT=8 with mem_done_i held 0 -> FAIL after 8 DRAIN cycles, timeout_o=1. Rerun with mem_done_i rising on cycle 8 -> DONE.
- Assert rst_i during DRAIN with counters at 10 -> all outputs 0 immediately. After release, the first commit at RESET_PC is accepted cleanly.

Source files
------------

// File: rtl/commit_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : commit_monitor                                               |
// | Description : Retire-side PC sequencing checker, CPI counters and          |
// |               end-of-test / memory drain handshake for 1..4 retire lanes.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module commit_monitor #(
    parameter int unsigned           ADDR_WIDTH     = 32,
    parameter int unsigned           RETIRE_W       = 1,
    parameter int unsigned           CNT_WIDTH      = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0,
    parameter logic [ADDR_WIDTH-1:0] END_PC         = ADDR_WIDTH'(88),
    parameter int unsigned           TIMEOUT_CYCLES = 100000,
    parameter int unsigned           DRAIN_TIMEOUT  = 1024
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [RETIRE_W-1:0]            commit_valid_i,
    input  logic [RETIRE_W*ADDR_WIDTH-1:0] commit_pc_i,
    input  logic [RETIRE_W*ADDR_WIDTH-1:0] commit_next_pc_i,
    input  logic                           mem_done_i,
    output logic                           finish_o,
    output logic [CNT_WIDTH-1:0]           cycle_count_o,
    output logic [CNT_WIDTH-1:0]           instr_count_o,
    output logic [ADDR_WIDTH-1:0]          last_pc_o,
    output logic                           seq_error_o,
    output logic [ADDR_WIDTH-1:0]          seq_error_pc_o,
    output logic                           timeout_o,
    output logic                           done_o,
    output logic                           pass_o
);

    localparam int unsigned c_LANE_W  = $clog2(RETIRE_W + 1);
    localparam int unsigned c_IDLE_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned c_DRAIN_W = $clog2(DRAIN_TIMEOUT + 1);

    localparam logic [1:0] c_S_RUN   = 2'd0;
    localparam logic [1:0] c_S_DRAIN = 2'd1;
    localparam logic [1:0] c_S_DONE  = 2'd2;
    localparam logic [1:0] c_S_FAIL  = 2'd3;

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_exp_pc;
    logic [ADDR_WIDTH-1:0] r_last_pc;
    logic [CNT_WIDTH-1:0]  r_cycle;
    logic [CNT_WIDTH-1:0]  r_instr;
    logic [c_IDLE_W-1:0]   r_idle;
    logic [c_DRAIN_W-1:0]  r_drain;
    logic                  r_finish;
    logic                  r_seq_error;
    logic [ADDR_WIDTH-1:0] r_seq_error_pc;
    logic                  r_timeout;
    logic                  r_done;

    logic [ADDR_WIDTH-1:0] w_pc      [RETIRE_W];
    logic [ADDR_WIDTH-1:0] w_next_pc [RETIRE_W];

    for (genvar g = 0; g < RETIRE_W; g++) begin : g_lane
        assign w_pc[g]      = commit_pc_i[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_next_pc[g] = commit_next_pc_i[g*ADDR_WIDTH +: ADDR_WIDTH];
    end

    logic                  w_any_valid;
    logic                  w_ended;
    logic                  w_gap;
    logic                  w_err;
    logic [ADDR_WIDTH-1:0] w_err_pc;
    logic [c_LANE_W-1:0]   w_acc_cnt;
    logic [ADDR_WIDTH-1:0] w_exp_pc;
    logic [ADDR_WIDTH-1:0] w_last_pc;
    logic                  w_first_found;
    logic [ADDR_WIDTH-1:0] w_first_pc;
    logic [CNT_WIDTH:0]    w_instr_sum;
    logic [CNT_WIDTH-1:0]  w_instr_next;
    logic [CNT_WIDTH-1:0]  w_cycle_next;
    logic [c_IDLE_W-1:0]   w_idle_next;
    logic [c_DRAIN_W-1:0]  w_drain_next;

    assign w_any_valid = |commit_valid_i;

    // Walk lanes in retire order; lanes after a gap or after END_PC are rejected.
    always_comb begin
        w_ended       = 1'b0;
        w_gap         = 1'b0;
        w_err         = 1'b0;
        w_err_pc      = '0;
        w_acc_cnt     = '0;
        w_exp_pc      = r_exp_pc;
        w_last_pc     = r_last_pc;
        w_first_found = 1'b0;
        w_first_pc    = '0;
        for (int k = 0; k < RETIRE_W; k++) begin
            if (commit_valid_i[k]) begin
                if (!w_first_found) begin
                    w_first_pc    = w_pc[k];
                    w_first_found = 1'b1;
                end
                if (w_ended || w_gap) begin
                    if (!w_err) w_err_pc = w_pc[k];
                    w_err = 1'b1;
                end else begin
                    if (w_pc[k] != w_exp_pc) begin
                        if (!w_err) w_err_pc = w_pc[k];
                        w_err = 1'b1;
                    end
                    w_acc_cnt = w_acc_cnt + c_LANE_W'(1);
                    w_last_pc = w_pc[k];
                    w_exp_pc  = w_next_pc[k];
                    if (w_pc[k] == END_PC) w_ended = 1'b1;
                end
            end else begin
                w_gap = 1'b1;
            end
        end
    end

    assign w_instr_sum  = {1'b0, r_instr} + {{(CNT_WIDTH + 1 - c_LANE_W){1'b0}}, w_acc_cnt};
    assign w_instr_next = w_instr_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : w_instr_sum[CNT_WIDTH-1:0];
    assign w_cycle_next = (&r_cycle) ? r_cycle : r_cycle + CNT_WIDTH'(1);
    assign w_idle_next  = r_idle + c_IDLE_W'(1);
    assign w_drain_next = r_drain + c_DRAIN_W'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state        <= c_S_RUN;
            r_exp_pc       <= RESET_PC;
            r_last_pc      <= '0;
            r_cycle        <= '0;
            r_instr        <= '0;
            r_idle         <= '0;
            r_drain        <= '0;
            r_finish       <= 1'b0;
            r_seq_error    <= 1'b0;
            r_seq_error_pc <= '0;
            r_timeout      <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            case (r_state)
                c_S_RUN: begin
                    r_cycle   <= w_cycle_next;
                    r_instr   <= w_instr_next;
                    r_exp_pc  <= w_exp_pc;
                    r_last_pc <= w_last_pc;
                    if (w_err && !r_seq_error) r_seq_error_pc <= w_err_pc;
                    if (w_err) r_seq_error <= 1'b1;
                    // A commit in the threshold cycle keeps the watchdog quiet.
                    if (w_ended) begin
                        r_state  <= c_S_DRAIN;
                        r_finish <= 1'b1;
                        r_drain  <= '0;
                    end else if (w_any_valid) begin
                        r_idle <= '0;
                    end else if (w_idle_next >= c_IDLE_W'(TIMEOUT_CYCLES)) begin
                        r_state   <= c_S_FAIL;
                        r_timeout <= 1'b1;
                        r_finish  <= 1'b1;
                        r_done    <= 1'b1;
                    end else begin
                        r_idle <= w_idle_next;
                    end
                end
                c_S_DRAIN: begin
                    if (w_any_valid && !r_seq_error) r_seq_error_pc <= w_first_pc;
                    if (w_any_valid) r_seq_error <= 1'b1;
                    if (mem_done_i) begin
                        r_state <= c_S_DONE;
                        r_done  <= 1'b1;
                    end else if (w_drain_next >= c_DRAIN_W'(DRAIN_TIMEOUT)) begin
                        r_state   <= c_S_FAIL;
                        r_timeout <= 1'b1;
                        r_done    <= 1'b1;
                    end else begin
                        r_drain <= w_drain_next;
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    assign finish_o       = r_finish;
    assign cycle_count_o  = r_cycle;
    assign instr_count_o  = r_instr;
    assign last_pc_o      = r_last_pc;
    assign seq_error_o    = r_seq_error;
    assign seq_error_pc_o = r_seq_error_pc;
    assign timeout_o      = r_timeout;
    assign done_o         = r_done;
    assign pass_o         = r_done & ~r_seq_error & ~r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_commit_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_commit_monitor                                            |
// | Description : Bench for commit_monitor: one single-lane and one dual-lane  |
// |               instance checked against a behavioural model.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_commit_monitor;

    localparam logic [31:0] c_END  = 32'd88;
    localparam longint      c_MAXC = 64'h0000_0000_FFFF_FFFF;
    localparam int M_RUN = 0, M_DRAIN = 1, M_DONE = 2, M_FAIL = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // single-lane instance A
    logic        va = 1'b0, mda = 1'b0;
    logic [31:0] pa = '0, na = '0;
    logic        fa, sea, toa, dna, psa;
    logic [31:0] cca, ica, lpa, sepa;
    // dual-lane instance B
    logic [1:0]  vb = '0;
    logic        mdb = 1'b0;
    logic [63:0] pb = '0, nb = '0;
    logic        fb, seb, tob, dnb, psb;
    logic [31:0] ccb, icb, lpb, sepb;

    commit_monitor #(
        .ADDR_WIDTH(32), .RETIRE_W(1), .CNT_WIDTH(32), .RESET_PC(32'd0),
        .END_PC(32'd88), .TIMEOUT_CYCLES(100000), .DRAIN_TIMEOUT(8)
    ) u_a (
        .clk_i(clk), .rst_i(rst), .commit_valid_i(va), .commit_pc_i(pa),
        .commit_next_pc_i(na), .mem_done_i(mda), .finish_o(fa),
        .cycle_count_o(cca), .instr_count_o(ica), .last_pc_o(lpa),
        .seq_error_o(sea), .seq_error_pc_o(sepa), .timeout_o(toa),
        .done_o(dna), .pass_o(psa)
    );

    commit_monitor #(
        .ADDR_WIDTH(32), .RETIRE_W(2), .CNT_WIDTH(32), .RESET_PC(32'd0),
        .END_PC(32'd88), .TIMEOUT_CYCLES(16), .DRAIN_TIMEOUT(8)
    ) u_b (
        .clk_i(clk), .rst_i(rst), .commit_valid_i(vb), .commit_pc_i(pb),
        .commit_next_pc_i(nb), .mem_done_i(mdb), .finish_o(fb),
        .cycle_count_o(ccb), .instr_count_o(icb), .last_pc_o(lpb),
        .seq_error_o(seb), .seq_error_pc_o(sepb), .timeout_o(tob),
        .done_o(dnb), .pass_o(psb)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state, index 0 = A, 1 = B
    int          st[2];
    longint      cyc[2], ins[2];
    logic [31:0] ex[2], lst[2], epc[2];
    bit          serr[2], tmo[2], fin[2], dn[2];
    int          idle[2], dc[2];

    function automatic void m_reset();
        for (int i = 0; i < 2; i++) begin
            st[i] = M_RUN; cyc[i] = 0; ins[i] = 0; ex[i] = '0; lst[i] = '0;
            epc[i] = '0; serr[i] = 0; tmo[i] = 0; fin[i] = 0; dn[i] = 0;
            idle[i] = 0; dc[i] = 0;
        end
    endfunction

    function automatic void m_step(int i, int w, int tlim, int dlim, logic [1:0] v,
                                   logic [63:0] p, logic [63:0] n, logic md);
        logic [31:0] pcs[2];
        logic [31:0] nps[2];
        logic [31:0] errq[$];
        int  pref, acc;
        bit  ended;
        pcs[0] = p[31:0]; pcs[1] = p[63:32];
        nps[0] = n[31:0]; nps[1] = n[63:32];
        ended = 0; acc = 0; pref = 0;
        case (st[i])
            M_RUN: begin
                cyc[i] = (cyc[i] < c_MAXC) ? cyc[i] + 1 : c_MAXC;
                while (pref < w && v[pref]) pref++;
                while (acc < pref && !ended) begin
                    if (pcs[acc] != ex[i]) errq.push_back(pcs[acc]);
                    lst[i] = pcs[acc];
                    ex[i]  = nps[acc];
                    ended  = (pcs[acc] == c_END);
                    acc++;
                end
                for (int k = acc; k < w; k++) if (v[k]) errq.push_back(pcs[k]);
                ins[i] = (ins[i] + acc > c_MAXC) ? c_MAXC : ins[i] + acc;
                if (errq.size() != 0 && !serr[i]) epc[i] = errq[0];
                if (errq.size() != 0) serr[i] = 1;
                if (ended) begin
                    st[i] = M_DRAIN; fin[i] = 1; dc[i] = 0;
                end else if (v != 2'b00) begin
                    idle[i] = 0;
                end else begin
                    idle[i]++;
                    if (idle[i] >= tlim) begin
                        st[i] = M_FAIL; tmo[i] = 1; fin[i] = 1; dn[i] = 1;
                    end
                end
            end
            M_DRAIN: begin
                dc[i]++;
                for (int k = 0; k < w; k++) if (v[k]) errq.push_back(pcs[k]);
                if (errq.size() != 0 && !serr[i]) epc[i] = errq[0];
                if (errq.size() != 0) serr[i] = 1;
                if (md) begin
                    st[i] = M_DONE; dn[i] = 1;
                end else if (dc[i] >= dlim) begin
                    st[i] = M_FAIL; tmo[i] = 1; dn[i] = 1;
                end
            end
            default: ;
        endcase
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp(string nm, int i, logic f, logic [31:0] cc, logic [31:0] ic,
                       logic [31:0] lp, logic se, logic [31:0] sep, logic to,
                       logic d, logic ps);
        chk({nm, ".finish"}, 64'(f), 64'(fin[i]));
        chk({nm, ".cycles"}, 64'(cc), cyc[i]);
        chk({nm, ".instrs"}, 64'(ic), ins[i]);
        chk({nm, ".last_pc"}, 64'(lp), 64'(lst[i]));
        chk({nm, ".seq_err"}, 64'(se), 64'(serr[i]));
        chk({nm, ".seq_err_pc"}, 64'(sep), 64'(epc[i]));
        chk({nm, ".timeout"}, 64'(to), 64'(tmo[i]));
        chk({nm, ".done"}, 64'(d), 64'(dn[i]));
        chk({nm, ".pass"}, 64'(ps), 64'(dn[i] && !serr[i] && !tmo[i]));
    endtask

    task automatic cmp_both();
        cmp("A", 0, fa, cca, ica, lpa, sea, sepa, toa, dna, psa);
        cmp("B", 1, fb, ccb, icb, lpb, seb, sepb, tob, dnb, psb);
    endtask

    task automatic tick();
        m_step(0, 1, 100000, 8, {1'b0, va}, {32'd0, pa}, {32'd0, na}, mda);
        m_step(1, 2, 16, 8, vb, pb, nb, mdb);
        @(posedge clk);
        #1;
        cmp_both();
    endtask

    // Called just after a rising edge: reset lands between edges to exercise the async path.
    task automatic do_reset();
        va = 1'b0; mda = 1'b0; vb = 2'b00; mdb = 1'b0;
        rst = 1'b1;
        #1;
        m_reset();
        cmp_both();
        #3;
        rst = 1'b0;
    endtask

    task automatic a_commit(logic [31:0] pc, logic [31:0] np);
        va = 1'b1; pa = pc; na = np;
        tick();
        va = 1'b0;
    endtask

    task automatic run_to_end_a();
        for (int p = 0; p <= 88; p += 4) a_commit(32'(p), 32'(p + 4));
    endtask

    function automatic logic [31:0] rnd_pc();
        return 32'($urandom_range(31, 0) * 4);
    endfunction

    logic [31:0] sa, sb, lp_b, ln_b;

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // straight-line program to END_PC, drain completes
        for (int p = 0; p <= 84; p += 4) a_commit(32'(p), 32'(p + 4));
        chk("tp1.finish_before_end", 64'(fa), 64'd0);
        a_commit(32'd88, 32'd92);
        chk("tp1.finish", 64'(fa), 64'd1);
        chk("tp1.instrs", 64'(ica), 64'd23);
        chk("tp1.cycles", 64'(cca), 64'd23);
        tick();
        tick();
        mda = 1'b1;
        tick();
        mda = 1'b0;
        chk("tp1.done", 64'(dna), 64'd1);
        chk("tp1.pass", 64'(psa), 64'd1);
        chk("tp1.cycles_frozen", 64'(cca), 64'd23);

        // taken branch then a sequencing break
        do_reset();
        a_commit(32'd0, 32'd4);
        a_commit(32'd4, 32'd8);
        a_commit(32'd8, 32'd40);
        a_commit(32'd40, 32'd44);
        chk("tp2.branch_ok", 64'(sea), 64'd0);
        a_commit(32'd48, 32'd52);
        chk("tp2.seq_err", 64'(sea), 64'd1);
        chk("tp2.seq_err_pc", 64'(sepa), 64'd48);
        a_commit(32'd52, 32'd56);
        chk("tp2.instrs", 64'(ica), 64'd6);
        chk("tp2.seq_err_pc_kept", 64'(sepa), 64'd48);

        // dual-lane gap then watchdog
        do_reset();
        vb = 2'b11; pb = {32'd4, 32'd0}; nb = {32'd8, 32'd4};
        tick();
        pb = {32'd12, 32'd8}; nb = {32'd16, 32'd12};
        tick();
        vb = 2'b10; pb = {32'd16, 32'd0}; nb = {32'd20, 32'd0};
        tick();
        vb = 2'b00;
        chk("tp3.gap_err", 64'(seb), 64'd1);
        chk("tp3.gap_pc", 64'(sepb), 64'd16);
        chk("tp3.instrs", 64'(icb), 64'd4);
        repeat (15) tick();
        chk("tp3.no_timeout_yet", 64'(tob), 64'd0);
        tick();
        chk("tp3.timeout", 64'(tob), 64'd1);
        chk("tp3.done", 64'(dnb), 64'd1);
        chk("tp3.pass", 64'(psb), 64'd0);

        // dual-lane end, post-end retire, drain timeout
        do_reset();
        vb = 2'b01; pb = {32'd0, 32'd0}; nb = {32'd0, 32'd4};
        tick();
        for (int j = 0; j <= 10; j++) begin
            vb = 2'b11;
            pb = {32'(8 + 8 * j), 32'(4 + 8 * j)};
            nb = {32'(12 + 8 * j), 32'(8 + 8 * j)};
            tick();
        end
        chk("tp4.finish", 64'(fb), 64'd1);
        chk("tp4.clean", 64'(seb), 64'd0);
        chk("tp4.instrs", 64'(icb), 64'd23);
        vb = 2'b01; pb = {32'd0, 32'd92}; nb = {32'd0, 32'd96};
        tick();
        vb = 2'b00;
        chk("tp4.post_end_err", 64'(seb), 64'd1);
        chk("tp4.post_end_pc", 64'(sepb), 64'd92);
        chk("tp4.instrs_frozen", 64'(icb), 64'd23);
        repeat (6) tick();
        chk("tp4.not_done", 64'(dnb), 64'd0);
        tick();
        chk("tp4.drain_timeout", 64'(tob), 64'd1);

        // drain timeout, then done winning on the timeout cycle
        do_reset();
        run_to_end_a();
        repeat (7) tick();
        chk("tp5.not_done", 64'(dna), 64'd0);
        tick();
        chk("tp5.done", 64'(dna), 64'd1);
        chk("tp5.timeout", 64'(toa), 64'd1);
        chk("tp5.pass", 64'(psa), 64'd0);
        do_reset();
        run_to_end_a();
        repeat (7) tick();
        mda = 1'b1;
        tick();
        mda = 1'b0;
        chk("tp5b.done", 64'(dna), 64'd1);
        chk("tp5b.timeout", 64'(toa), 64'd0);
        chk("tp5b.pass", 64'(psa), 64'd1);

        // reset in DRAIN with counters at 10
        do_reset();
        a_commit(32'd0, 32'd56);
        for (int p = 56; p <= 88; p += 4) a_commit(32'(p), 32'(p + 4));
        chk("tp6.instrs", 64'(ica), 64'd10);
        chk("tp6.cycles", 64'(cca), 64'd10);
        tick();
        do_reset();
        chk("tp6.rst_instrs", 64'(ica), 64'd0);
        chk("tp6.rst_finish", 64'(fa), 64'd0);
        a_commit(32'd0, 32'd4);
        chk("tp6.first_instr", 64'(ica), 64'd1);
        chk("tp6.first_clean", 64'(sea), 64'd0);

        // randomized episodes: mostly sequential code with jumps, bad PCs and lane gaps
        for (int e = 0; e < 8; e++) begin
            do_reset();
            sa = '0;
            sb = '0;
            for (int c = 0; c < 60; c++) begin
                va = (($urandom % 4) != 0);
                if (va) begin
                    pa = (($urandom % 8) == 0) ? rnd_pc() : sa;
                    na = (($urandom % 4) == 0) ? rnd_pc() : pa + 32'd4;
                    sa = na;
                end
                mda = (($urandom % 4) == 0);
                vb  = 2'($urandom);
                for (int k = 0; k < 2; k++) begin
                    if (vb[k]) begin
                        lp_b = (($urandom % 8) == 0) ? rnd_pc() : sb;
                        ln_b = (($urandom % 4) == 0) ? rnd_pc() : lp_b + 32'd4;
                        sb   = ln_b;
                    end else begin
                        lp_b = rnd_pc();
                        ln_b = rnd_pc();
                    end
                    pb[k*32 +: 32] = lp_b;
                    nb[k*32 +: 32] = ln_b;
                end
                mdb = (($urandom % 4) == 0);
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
